// File: rtl/mmio_fb_writer_if.sv
// Command and write-bus signals between a command producer and the framebuffer writer.
interface mmio_fb_writer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_start;
  logic [10:0] cmd_len;
  logic [7:0]  cmd_data;
  logic        cmd_incr;
  logic        cmd_abort;
  logic        bus_clock;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data;
  logic        bus_rw;
  logic        busy;
  logic        done;

  modport master (
    output cmd_valid, cmd_start, cmd_len, cmd_data, cmd_incr, cmd_abort,
    input  cmd_ready, bus_clock, bus_addr, bus_data, bus_rw, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_start, cmd_len, cmd_data, cmd_incr, cmd_abort,
    output cmd_ready, bus_clock, bus_addr, bus_data, bus_rw, busy, done
  );
endinterface

// File: rtl/mmio_fb_writer.sv
// Streams fill (or, with FB_WRITER_INCR_EN, incrementing) bytes into a framebuffer over a
// phase-clocked MMIO bus: one write per HIGH+LOW bus_clock pair, cmd_ready = ~busy.
module mmio_fb_writer #(
  parameter int          HALF_PERIOD = 2,
  parameter logic [15:0] FB_BASE     = 16'h0200,
  parameter int          FB_SIZE     = 1024
) (
  input logic CLOCK_50,
  input logic reset,
  mmio_fb_writer_if.slave mif
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, FINISH} state_t;

  localparam logic [7:0]  HP_LAST = 8'(HALF_PERIOD - 1);
  localparam logic [11:0] SIZE_L  = 12'(FB_SIZE);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [11:0] remain_q;
  logic [11:0] offset_q;
  logic [15:0] addr_q;
  logic [7:0]  data_q;
  logic        abort_q;

  logic        accept;
  logic        half_done;
  logic        more;
  logic        advance;
  logic [11:0] eff_len;
  logic [11:0] start_ofs;
  logic [11:0] next_ofs;
  logic [7:0]  next_data;

  assign accept    = mif.cmd_valid && (state_q == IDLE);
  assign half_done = (cnt_q == HP_LAST);
  assign eff_len   = ({1'b0, mif.cmd_len} > SIZE_L) ? SIZE_L : {1'b0, mif.cmd_len};
  assign start_ofs = {2'b00, mif.cmd_start} % SIZE_L;
  assign next_ofs  = (offset_q == SIZE_L - 12'd1) ? 12'd0 : offset_q + 12'd1;
  // An abort arriving on the final LOW cycle still stops before the next write.
  assign more      = (remain_q != 12'd1) && !abort_q && !mif.cmd_abort;
  assign advance   = (state_q == LOW) && half_done && more;

`ifdef FB_WRITER_INCR_EN
  logic incr_q;
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)       incr_q <= 1'b0;
    else if (accept) incr_q <= mif.cmd_incr;
  end
  assign next_data = incr_q ? data_q + 8'd1 : data_q;
`else
  logic unused_incr;
  assign unused_incr = mif.cmd_incr;
  assign next_data   = data_q;
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (eff_len == 12'd0) ? FINISH : HIGH;
      HIGH:    if (half_done) state_d = LOW;
      LOW:     if (half_done) state_d = more ? HIGH : FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q    <= 8'd0;
      remain_q <= 12'd0;
      offset_q <= 12'd0;
      addr_q   <= 16'd0;
      data_q   <= 8'd0;
      abort_q  <= 1'b0;
    end else begin
      cnt_q <= ((state_q == HIGH || state_q == LOW) && state_d == state_q) ? cnt_q + 8'd1 : 8'd0;
      if (state_q == IDLE)   abort_q <= 1'b0;
      else if (mif.cmd_abort) abort_q <= 1'b1;
      if (accept) begin
        remain_q <= eff_len;
        offset_q <= start_ofs;
        addr_q   <= FB_BASE + {4'b0000, start_ofs};
        data_q   <= mif.cmd_data;
      end else if (advance) begin
        remain_q <= remain_q - 12'd1;
        offset_q <= next_ofs;
        addr_q   <= FB_BASE + {4'b0000, next_ofs};
        data_q   <= next_data;
      end
    end
  end

  assign mif.cmd_ready = (state_q == IDLE);
  assign mif.busy      = (state_q != IDLE);
  assign mif.done      = (state_q == FINISH);
  assign mif.bus_clock = (state_q != LOW);
  assign mif.bus_rw    = !(state_q == HIGH || state_q == LOW);
  assign mif.bus_addr  = addr_q;
  assign mif.bus_data  = data_q;

endmodule

// File: tb/tb_mmio_fb_writer.sv
// Directed self-checking bench for mmio_fb_writer at HALF_PERIOD=2.
module tb_mmio_fb_writer;
  logic CLOCK_50 = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  mmio_fb_writer_if mif ();

  mmio_fb_writer #(.HALF_PERIOD(2), .FB_BASE(16'h0200), .FB_SIZE(1024)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .mif      (mif)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [15:0] wr_addr [0:1099];
  logic [7:0]  wr_data [0:1099];
  int          wr_low  [0:1099];
  int          n_wr, done_cyc, done_cnt, unstable;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one command and records every write until done (plus two trailing cycles).
  task automatic run_cmd(input logic [9:0] start, input logic [10:0] len, input logic [7:0] data,
                         input logic incr, input int abort_at);
    bit prev_rw, prev_clk, aborted;
    n_wr = 0; done_cyc = -1; done_cnt = 0; unstable = 0;
    prev_rw = 1'b1; prev_clk = 1'b1; aborted = 1'b0;
    @(negedge CLOCK_50);
    mif.cmd_start = start; mif.cmd_len = len; mif.cmd_data = data; mif.cmd_incr = incr;
    mif.cmd_valid = 1'b1;
    @(posedge CLOCK_50);
    #1 mif.cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 6000; cyc++) begin
      @(negedge CLOCK_50);
      mif.cmd_abort = 1'b0;
      if (mif.bus_rw === 1'b0) begin
        if (prev_rw || (!prev_clk && mif.bus_clock === 1'b1)) begin
          if (n_wr < 1100) begin
            wr_addr[n_wr] = mif.bus_addr;
            wr_data[n_wr] = mif.bus_data;
            wr_low[n_wr]  = 1;
          end
          n_wr++;
        end else if (n_wr <= 1100) begin
          wr_low[n_wr-1]++;
          if (mif.bus_addr !== wr_addr[n_wr-1] || mif.bus_data !== wr_data[n_wr-1]) unstable++;
        end
        if (abort_at == n_wr && mif.bus_clock === 1'b0 && !aborted) begin
          mif.cmd_abort = 1'b1;
          aborted = 1'b1;
        end
      end
      if (mif.done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      prev_rw  = mif.bus_rw;
      prev_clk = mif.bus_clock;
    end
  endtask

  initial begin
    mif.cmd_valid = 1'b0; mif.cmd_start = '0; mif.cmd_len = '0;
    mif.cmd_data = '0; mif.cmd_incr = 1'b0; mif.cmd_abort = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_ready", mif.cmd_ready, 1);
    chk("rst_busy", mif.busy, 0);
    chk("rst_done", mif.done, 0);
    chk("rst_bus_clock", mif.bus_clock, 1);
    chk("rst_bus_rw", mif.bus_rw, 1);
    chk("rst_addr", mif.bus_addr, 16'h0000);
    chk("rst_data", mif.bus_data, 8'h00);
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50) reset = 1'b0;

    // Fill: three bytes of 0x41 at offset 0
    run_cmd(10'd0, 11'd3, 8'h41, 1'b0, 0);
    chk("fill_nwr", n_wr, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fill_addr%0d", i), wr_addr[i], 16'h0200 + 16'(i));
      chk($sformatf("fill_data%0d", i), wr_data[i], 8'h41);
      chk($sformatf("fill_low%0d", i), wr_low[i], 4);
    end
    chk("fill_done_cyc", done_cyc, 13);
    chk("fill_done_cnt", done_cnt, 1);
    chk("fill_stable", unstable, 0);
    chk("fill_ready_after", mif.cmd_ready, 1);

    // Wrap across the end of the framebuffer
    run_cmd(10'd1022, 11'd4, 8'h11, 1'b0, 0);
    chk("wrap_nwr", n_wr, 4);
    chk("wrap_addr0", wr_addr[0], 16'h05FE);
    chk("wrap_addr1", wr_addr[1], 16'h05FF);
    chk("wrap_addr2", wr_addr[2], 16'h0200);
    chk("wrap_addr3", wr_addr[3], 16'h0201);
    chk("wrap_done_cyc", done_cyc, 17);

    // Zero length finishes immediately with no writes
    run_cmd(10'd5, 11'd0, 8'h22, 1'b0, 0);
    chk("zero_nwr", n_wr, 0);
    chk("zero_done_cyc", done_cyc, 1);
    chk("zero_done_cnt", done_cnt, 1);

    // Oversize length clamps to the framebuffer size
    run_cmd(10'd0, 11'd2000, 8'h33, 1'b0, 0);
    chk("clamp_nwr", n_wr, 1024);
    chk("clamp_last_addr", wr_addr[1023], 16'h05FF);
    chk("clamp_done_cyc", done_cyc, 4097);
    chk("clamp_stable", unstable, 0);

    // Abort during LOW of write 2 of 10
    run_cmd(10'd100, 11'd10, 8'h5A, 1'b0, 2);
    chk("abort_nwr", n_wr, 2);
    chk("abort_low1", wr_low[1], 4);
    chk("abort_done_cyc", done_cyc, 9);
    chk("abort_done_cnt", done_cnt, 1);

    // Abort while idle has no effect on the next command
    @(negedge CLOCK_50) mif.cmd_abort = 1'b1;
    @(negedge CLOCK_50) mif.cmd_abort = 1'b0;
    run_cmd(10'd7, 11'd2, 8'h77, 1'b0, 0);
    chk("idle_abort_nwr", n_wr, 2);
    chk("idle_abort_addr1", wr_addr[1], 16'h0208);

    // Pattern mode
    run_cmd(10'd0, 11'd3, 8'hFE, 1'b1, 0);
    chk("pat_nwr", n_wr, 3);
    chk("pat_data0", wr_data[0], 8'hFE);
`ifdef FB_WRITER_INCR_EN
    chk("pat_data1", wr_data[1], 8'hFF);
    chk("pat_data2", wr_data[2], 8'h00);
`else
    chk("pat_data1", wr_data[1], 8'hFE);
    chk("pat_data2", wr_data[2], 8'hFE);
`endif

    // Reset during HIGH of the first write
    @(negedge CLOCK_50);
    mif.cmd_start = 10'd3; mif.cmd_len = 11'd5; mif.cmd_data = 8'h99; mif.cmd_valid = 1'b1;
    @(posedge CLOCK_50);
    #1 mif.cmd_valid = 1'b0;
    @(negedge CLOCK_50);
    chk("rstmid_pre_rw", mif.bus_rw, 0);
    chk("rstmid_pre_clk", mif.bus_clock, 1);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_rw", mif.bus_rw, 1);
    chk("rstmid_busy", mif.busy, 0);
    chk("rstmid_ready", mif.cmd_ready, 1);
    chk("rstmid_addr", mif.bus_addr, 16'h0000);
    chk("rstmid_data", mif.bus_data, 8'h00);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50) reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLOCK_50);
      if (mif.done === 1'b1) done_cnt++;
    end
    chk("rstmid_no_done", done_cnt, 0);
    chk("rstmid_idle_rw", mif.bus_rw, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mmio_fb_writer.md
MMIO_FB_WRITER -- requirements
Module: mmio_fb_writer

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 2: CLOCK_50 cycles per bus_clock half-period (valid range 1..255).
REQ-002 SHALL have parameter FB_BASE, default 16'h0200: first framebuffer bus address.
REQ-003 SHALL have parameter FB_SIZE, default 1024: framebuffer bytes (0x200..0x5FF).
REQ-004 SHALL have port CLOCK_50, input, 1 bit: sole clock, all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-006 SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-007 SHALL have port cmd_ready, output, 1 bit: high when the block can accept a command.
REQ-008 SHALL have port cmd_start, input, 10 bits: framebuffer byte offset of the first write.
REQ-009 SHALL have port cmd_len, input, 11 bits: number of bytes to write.
REQ-010 SHALL have port cmd_data, input, 8 bits: fill value or initial pattern value.
REQ-011 SHALL have port cmd_incr, input, 1 bit: pattern mode select.
REQ-012 SHALL have port cmd_abort, input, 1 bit: stop the active command.
REQ-013 SHALL have port bus_clock, output, 1 bit: bus phase clock; responders sample on its falling edge.
REQ-014 SHALL have port bus_addr, output, 16 bits: bus address.
REQ-015 SHALL have port bus_data, output, 8 bits: write data.
REQ-016 SHALL have port bus_rw, output, 1 bit: bus direction, write active-low.
REQ-017 SHALL have port busy, output, 1 bit: high while a command is active.
REQ-018 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-019 SHALL accept a command on a CLOCK_50 edge with cmd_valid and cmd_ready both high; cmd_ready SHALL equal ~busy.
REQ-020 SHALL use states IDLE, HIGH, LOW, FINISH: IDLE->HIGH on accept with effective length nonzero; IDLE->FINISH on accept with effective length 0; HIGH->LOW after HALF_PERIOD cycles; LOW->HIGH after HALF_PERIOD cycles if bytes remain and no abort is latched; LOW->FINISH otherwise; FINISH->IDLE after one cycle.
REQ-021 SHALL drive bus_clock=1 in IDLE, HIGH and FINISH, and bus_clock=0 in LOW.
REQ-022 SHALL drive bus_rw=0 in HIGH and LOW and bus_rw=1 in IDLE and FINISH.
REQ-023 SHALL hold bus_addr and bus_data stable for the entire HIGH+LOW pair of each write, with the first write's values valid on the first HIGH cycle.
REQ-024 SHALL compute bus_addr as FB_BASE + (offset mod FB_SIZE); offset starts at cmd_start and increments by 1 per write, wrapping 1023->0.
REQ-025 SHALL use effective length min(cmd_len, FB_SIZE); cmd_len values 1025..2047 SHALL be clamped to 1024.
REQ-026 SHALL hold bus_data at cmd_data for every write in fill mode (cmd_incr=0).
REQ-027 SHALL latch cmd_abort in any non-IDLE state, complete the current HIGH+LOW pair, then enter FINISH; cmd_abort in IDLE SHALL be ignored.
REQ-028 SHALL assert busy in HIGH, LOW and FINISH, and SHALL pulse done for exactly the FINISH cycle.
REQ-029 SHALL produce a throughput of one write per 2*HALF_PERIOD CLOCK_50 cycles, with no idle gap between consecutive writes.

Reset
REQ-030 SHALL, while reset is high, asynchronously force IDLE, bus_clock=1, bus_rw=1, bus_addr=0, bus_data=0, busy=0, done=0 and cmd_ready=1, including mid-write; no done pulse SHALL follow a reset.

Configuration
REQ-031 SHALL compile pattern mode only when FB_WRITER_INCR_EN is defined: with cmd_incr=1, bus_data SHALL start at cmd_data and increment by 1 (mod 256) per write.
REQ-032 SHALL, without FB_WRITER_INCR_EN, ignore cmd_incr and always operate in fill mode.

Verification (HALF_PERIOD=2)
REQ-033 SHALL verify fill: start=0, len=3, data=0x41 -> writes 0x41 to 0x0200, 0x0201 and 0x0202, each bus_rw=0 for 4 cycles, done in cycle 13 after accept.
REQ-034 SHALL verify wrap: start=1022, len=4 -> bus_addr sequence 0x05FE, 0x05FF, 0x0200, 0x0201.
REQ-035 SHALL verify zero length and clamp: len=0 -> no bus_rw=0 and done on the next cycle; len=2000 -> exactly 1024 writes.
REQ-036 SHALL verify abort: abort asserted mid-LOW of write 2 of 10 -> write 2 completes, then FINISH with done, and exactly 2 writes total.
REQ-037 SHALL verify reset: reset asserted during HIGH -> bus_rw=1, busy=0 and cmd_ready=1 immediately, with no done pulse.
REQ-038 SHALL verify pattern (FB_WRITER_INCR_EN defined): data=0xFE, incr=1, len=3 -> data sequence 0xFE, 0xFF, 0x00; with the macro undefined, the same stimulus -> 0xFE on all three writes.
